// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler: time-shares one serializer lane among NUM_REQ word
// sources. Round-robin grant, word capture, load/enable sequencing, retire on
// ser_tx_done, and a watchdog for a serializer that never reports done.
module serdes_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 64,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          ser_enable,
    output logic                          ser_mode,
    output logic                          ser_load,
    output logic [DATA_WIDTH-1:0]         ser_parallel,
    input  logic                          ser_tx_done,
    output logic                          busy,
    output logic [IDW-1:0]                active_id,
    output logic                          sent_valid,
    output logic [IDW-1:0]                sent_id,
    output logic                          timeout_err,
    input  logic                          err_clear
);
    // One counter serves both the SHIFT watchdog and the GAP length.
    localparam int TMAX     = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TW       = $clog2(TMAX + 1);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IDW-1:0]        rr_q, rr_d;
    logic [IDW-1:0]        active_q, active_d;
    logic [IDW-1:0]        sent_id_q, sent_id_d;
    logic                  sent_valid_q, sent_valid_d;
    logic                  err_q, err_d;
    logic                  ser_enable_q, ser_enable_d;
    logic                  ser_load_q, ser_load_d;
    logic                  busy_q, busy_d;
    logic [IDW-1:0]        grant_idx;
    logic                  grant_found;
    logic                  take;

    // Index arithmetic modulo NUM_REQ without a divider (off < NUM_REQ).
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_add(rr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_q, k);
            end
        end
    end

    // The only place req_ready can be high: an accepted grant out of IDLE.
    assign take = (state_q == S_IDLE) && enable && grant_found && !rst;

    // One-hot accept toward the winning requester.
    always_comb begin
        req_ready = '0;
        if (take) req_ready[grant_idx] = 1'b1;
    end

    // Next-state and datapath decisions for the lane sequencer.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        timer_d      = timer_q;
        rr_d         = rr_q;
        active_d     = active_q;
        sent_id_d    = sent_id_q;
        sent_valid_d = 1'b0;
        err_d        = err_clear ? 1'b0 : err_q;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    hold_d   = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    active_d = grant_idx;
                    rr_d     = wrap_add(grant_idx, 1);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                timer_d = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                timer_d = timer_q + 1'b1;
                // done takes priority over a watchdog expiry in the same cycle
                if (ser_tx_done || timer_q == TW'(TIMEOUT - 1)) begin
                    if (ser_tx_done) begin
                        sent_valid_d = 1'b1;
                        sent_id_d    = active_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    timer_d = '0;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q == TW'(GAP_LAST)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ser_enable_d = (state_d == S_LOAD) || (state_d == S_SHIFT);
        ser_load_d   = (state_d == S_LOAD);
        busy_d       = (state_d != S_IDLE);
    end

    // State and registered outputs; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            timer_q      <= '0;
            rr_q         <= '0;
            active_q     <= '0;
            sent_id_q    <= '0;
            sent_valid_q <= 1'b0;
            err_q        <= 1'b0;
            ser_enable_q <= 1'b0;
            ser_load_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            timer_q      <= timer_d;
            rr_q         <= rr_d;
            active_q     <= active_d;
            sent_id_q    <= sent_id_d;
            sent_valid_q <= sent_valid_d;
            err_q        <= err_d;
            ser_enable_q <= ser_enable_d;
            ser_load_q   <= ser_load_d;
            busy_q       <= busy_d;
        end
    end

    assign ser_enable   = ser_enable_q;
    assign ser_load     = ser_load_q;
    assign ser_mode     = 1'b0;
    assign ser_parallel = hold_q;
    assign busy         = busy_q;
    assign active_id    = active_q;
    assign sent_valid   = sent_valid_q;
    assign sent_id      = sent_id_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Bench for serdes_tx_scheduler: attached serializer stand-in, a word-level
// reference model checked every cycle, a vector table, directed corner cases
// and a randomized run.
module tb_serdes_tx_scheduler;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 1;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst, enable, err_clear, ser_tx_done;
    logic [N-1:0]      req_valid, req_ready;
    logic [N*DW-1:0]   req_data;
    logic              ser_enable, ser_mode, ser_load, busy, sent_valid, timeout_err;
    logic [DW-1:0]     ser_parallel;
    logic [IDW-1:0]    active_id, sent_id;

    always #5 clk = ~clk;

    serdes_tx_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_enable(ser_enable), .ser_mode(ser_mode), .ser_load(ser_load),
        .ser_parallel(ser_parallel), .ser_tx_done(ser_tx_done), .busy(busy), .active_id(active_id),
        .sent_valid(sent_valid), .sent_id(sent_id), .timeout_err(timeout_err), .err_clear(err_clear)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serializer stand-in: captures on load, reports done on SHIFT cycle done_after.
    int            done_after = 9;
    int            sc = 0;
    logic [DW-1:0] sh;
    logic          serial_out;
    always @(posedge clk) begin
        if (rst)              sc <= 0;
        else if (ser_load)    begin sh <= ser_parallel; sc <= 1; end
        else if (!ser_enable) sc <= 0;
        else if (sc != 0)     sc <= sc + 1;
    end
    always_comb begin
        serial_out = 1'b0;
        if (sc >= 1 && sc <= DW) serial_out = sh[DW - sc];
    end
    assign ser_tx_done = ser_enable && !ser_load && (sc == done_after);

    // Reference model: a word occupies m_e = 1 (load), 2..1+S (shift), then GAP
    // cycles, where S = min(done_after, TO); m_e = 0 means idle.
    int            m_e = 0, m_S = 0, m_ptr = 0, m_owner = 0, m_sid = 0, m_g = 0, m_g2 = 0;
    bit            m_to = 0, m_err = 0, m_sv = 0, m_set = 0;
    logic [DW-1:0] m_hold = '0;
    logic [N-1:0]  m_rdy;

    function automatic int m_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_e = 0; m_ptr = 0; m_owner = 0; m_sid = 0; m_err = 0; m_sv = 0; m_hold = '0;
        end else begin
            m_sv  = 0;
            m_set = 0;
            if (m_e == 0) begin
                m_g = enable ? m_pick(req_valid, m_ptr) : -1;
                if (m_g >= 0) begin
                    m_hold  = req_data[m_g*DW +: DW];
                    m_owner = m_g;
                    m_ptr   = (m_g + 1) % N;
                    m_S     = (done_after < TO) ? done_after : TO;
                    m_to    = (done_after > TO);
                    m_e     = 1;
                end
            end else begin
                if (m_e == 1 + m_S) begin
                    if (m_to) m_set = 1;
                    else begin m_sv = 1; m_sid = m_owner; end
                end
                if (m_e >= 1 + m_S + GAP) m_e = 0;
                else m_e++;
            end
            if (m_set) m_err = 1;
            else if (err_clear) m_err = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        m_rdy = '0;
        if (m_e == 0 && enable && !rst) begin
            m_g2 = m_pick(req_valid, m_ptr);
            if (m_g2 >= 0) m_rdy[m_g2] = 1'b1;
        end
        chk("req_ready", req_ready, m_rdy);
        chk("busy", busy, m_e != 0);
        chk("ser_enable", ser_enable, (m_e >= 1) && (m_e <= 1 + m_S));
        chk("ser_load", ser_load, m_e == 1);
        chk("ser_mode", ser_mode, 1'b0);
        chk("ser_parallel", ser_parallel, m_hold);
        chk("active_id", active_id, m_owner);
        chk("sent_valid", sent_valid, m_sv);
        chk("sent_id", sent_id, m_sid);
        chk("timeout_err", timeout_err, m_err);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_valid = '0; tick(); rst = 1'b1; tick(); rst = 1'b0;
    endtask

    // Returns at the negedge of the grant cycle t.
    task automatic wait_grant(output int g, output int t);
        g = -1; t = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                t = cyc;
                return;
            end
            tick();
        end
        errors++; checks++;
        $display("FAIL grant_wait: no req_ready within 200 cycles (cycle %0d)", cyc);
    endtask

    task automatic wait_idle(output bit saw, output int sid);
        saw = 0; sid = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sent_valid) begin saw = 1; sid = int'(sent_id); end
            if (!busy) return;
            tick();
        end
        errors++; checks++;
        $display("FAIL idle_wait: busy stuck for 100 cycles (cycle %0d)", cyc);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int           d;
        int           exp_id;
        bit           exp_sent;
        bit           exp_err;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int g, t, t0, sid;
        bit saw;
        logic [DW-1:0] w;
        int exp2[5];
        int exp3[5];

        rst = 1'b1; enable = 1'b0; err_clear = 1'b0; req_valid = '0;
        req_data = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ser_enable", ser_enable, 0);
        chk("rst_ser_load", ser_load, 0);
        chk("rst_active_id", active_id, 0);
        chk("rst_sent_valid", sent_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // Vector table: back-to-back words from IDLE, pointer evolving from 0.
        vecs[0] = '{4'b0001,  9, 0, 1'b1, 1'b0};
        vecs[1] = '{4'b0011,  9, 1, 1'b1, 1'b0};
        vecs[2] = '{4'b1001,  3, 3, 1'b1, 1'b0};
        vecs[3] = '{4'b1111, 16, 0, 1'b1, 1'b0};
        vecs[4] = '{4'b0100, 17, 2, 1'b0, 1'b1};
        vecs[5] = '{4'b0111,  1, 0, 1'b1, 1'b1};
        vecs[6] = '{4'b1100,  2, 2, 1'b1, 1'b1};
        vecs[7] = '{4'b1000,  5, 3, 1'b1, 1'b1};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            done_after = vecs[i].d;
            req_valid  = vecs[i].mask;
            wait_grant(g, t);
            chk($sformatf("vec%0d_id", i), g, vecs[i].exp_id);
            tick(); req_valid = '0;
            wait_idle(saw, sid);
            chk($sformatf("vec%0d_sent", i), saw, vecs[i].exp_sent);
            if (vecs[i].exp_sent) chk($sformatf("vec%0d_sent_id", i), sid, vecs[i].exp_id);
            chk($sformatf("vec%0d_err", i), timeout_err, vecs[i].exp_err);
            tick();
        end
        err_clear = 1'b1; tick(); err_clear = 1'b0;

        // 1: single word 0xA5, exact latency and serial bit order
        do_reset();
        done_after = 9; req_valid = 4'b0001; w = 8'hA5;
        wait_grant(g, t);
        chk("t1_id", g, 0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            @(negedge clk);
            if (c == 1) begin chk("t1_load", ser_load, 1); chk("t1_word", ser_parallel, 8'hA5); end
            if (c >= 2 && c <= 9) chk($sformatf("t1_bit%0d", c - 2), serial_out, w[9 - c]);
            if (c == 10) chk("t1_done_cycle", ser_tx_done, 1);
            if (c == 11) begin chk("t1_sent_valid", sent_valid, 1); chk("t1_sent_id", sent_id, 0); end
            if (c == 12) chk("t1_busy_low", busy, 0);
        end

        // 2: full load, grants 0,1,2,3,0 twelve cycles apart
        do_reset();
        exp2 = '{0, 1, 2, 3, 0};
        req_valid = 4'b1111; t0 = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, t);
            chk($sformatf("t2_grant%0d", i), g, exp2[i]);
            if (i > 0) chk($sformatf("t2_period%0d", i), t - t0, 12);
            t0 = t;
            tick();
        end
        req_valid = '0;
        wait_idle(saw, sid);

        // 3: only 1 and 3 valid, then req 0 rises mid-run after the wrap
        do_reset();
        exp3 = '{1, 3, 1, 3, 0};
        req_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, t);
            chk($sformatf("t3_grant%0d", i), g, exp3[i]);
            tick();
            if (i == 3) req_valid = 4'b1011;
        end
        req_valid = '0;
        wait_idle(saw, sid);

        // 4: watchdog with a serializer that never reports done
        do_reset();
        done_after = 1000; req_valid = 4'b0001;
        wait_grant(g, t);
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            @(negedge clk);
            chk("t4_no_sent", sent_valid, 0);
            if (c == 17) chk("t4_err_before", timeout_err, 0);
            if (c == 18) chk("t4_err_set", timeout_err, 1);
            if (c == 19) chk("t4_idle", busy, 0);
        end
        tick(); err_clear = 1'b1; tick(); err_clear = 1'b0;
        @(negedge clk);
        chk("t4_cleared", timeout_err, 0);
        tick();
        err_clear = 1'b1; req_valid = 4'b0001;
        wait_grant(g, t);
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            @(negedge clk);
            if (c == 18) chk("t4_set_wins", timeout_err, 1);
        end
        tick(); err_clear = 1'b0;
        wait_idle(saw, sid);
        done_after = 9;

        // 5: reset on the 4th SHIFT cycle, then a fresh grant from pointer 0
        do_reset();
        req_valid = 4'b0100;
        wait_grant(g, t);
        chk("t5_first", g, 2);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) begin rst = 1'b1; req_valid = 4'b1100; end
            if (c == 6) rst = 1'b0;
        end
        wait_grant(g, t0);
        chk("t5_regrant_id", g, 2);
        chk("t5_regrant_cycle", t0 - t, 6);
        chk("t5_busy0", busy, 0);
        chk("t5_ser_enable0", ser_enable, 0);
        chk("t5_active0", active_id, 0);
        chk("t5_parallel0", ser_parallel, 0);
        tick(); req_valid = '0;
        @(negedge clk);
        chk("t5_reload", ser_parallel, 8'h5A);
        wait_idle(saw, sid);
        chk("t5_sent", saw, 1);
        chk("t5_sent_id", sid, 2);

        // 6: enable dropped mid-word; pending request waits for enable
        do_reset();
        req_valid = 4'b0001;
        wait_grant(g, t);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1)  req_valid = 4'b0010;
            if (c == 3)  enable = 1'b0;
            if (c == 16) enable = 1'b1;
            @(negedge clk);
            if (c == 5)  chk("t6_still_enabled", ser_enable, 1);
            if (c == 11) begin chk("t6_sent", sent_valid, 1); chk("t6_sent_id", sent_id, 0); end
            if (c >= 12 && c <= 15) chk($sformatf("t6_blocked%0d", c), req_ready, 4'b0000);
            if (c == 16) chk("t6_regrant", req_ready, 4'b0010);
        end
        tick(); req_valid = '0;
        wait_idle(saw, sid);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            tick();
            req_valid = N'($urandom);
            req_data  = {$urandom, $urandom};
            enable    = ($urandom_range(0, 7) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            if (m_e == 0) done_after = $urandom_range(1, 20);
        end
        tick();
        rst = 1'b0; req_valid = '0; err_clear = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serdes_tx_scheduler.md
Name: serdes_tx_scheduler

Overview:
Shares one parameterized serializer among NUM_REQ parallel-word requesters. It arbitrates round-robin, captures the granted word, and drives the serializer's load/enable controls. It watches tx_done to retire each word, with a watchdog for a hung serializer. It sits between per-channel packet sources and a single serializer lane.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, parallel word width; must match the attached serializer
GAP_CYCLES, 1, idle cycles inserted after each word before the next grant (0 allowed)
TIMEOUT, 64, max SHIFT-state cycles waiting for ser_tx_done before error (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  permits new grants
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*DATA_WIDTH  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot accept; handshake when valid&ready
ser_enable  output  1  serializer enable
ser_mode  output  1  serializer mode, constant 0 (serialize)
ser_load  output  1  serializer load strobe
ser_parallel  output  DATA_WIDTH  word to serializer
ser_tx_done  input  1  serializer transmission complete
busy  output  1  state != IDLE
active_id  output  clog2(NUM_REQ)  requester currently owning the lane
sent_valid  output  1  one-cycle pulse: word fully shifted
sent_id  output  clog2(NUM_REQ)  id of retired word, valid with sent_valid
timeout_err  output  1  sticky watchdog error
err_clear  input  1  clears timeout_err

Behaviour:
- Synchronous reset, active-high, dominates everything.
- On reset: state IDLE; rr pointer 0; hold register 0; timer 0; every output 0 (req_ready, ser_*, busy, active_id, sent_valid, sent_id, timeout_err). ser_mode is always 0.
- Reset mid-operation aborts the word with no sent_valid. The next cycle is IDLE.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - If enable and |req_valid, grant the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in that cycle only. It is the sole place req_ready is ever 1.
  - On the clock edge: hold <= req_data[g], active_id <= g, pointer <= (g+1) mod NUM_REQ, go to LOAD.
  - Requesters must not make req_valid depend on req_ready.
  - If enable is low, no grant.
- LOAD (1 cycle): ser_enable=1, ser_load=1, ser_parallel=hold. Next state SHIFT, timer <= 0.
- SHIFT:
  - ser_enable=1, ser_load=0, ser_parallel=hold. timer increments each cycle.
  - If ser_tx_done=1: retire the word. Go to GAP, or to IDLE if GAP_CYCLES=0.
  - Else if timer == TIMEOUT-1: timeout_err <= 1 and leave as above, with no sent_valid. A done in the same cycle wins.
- GAP: ser_enable=0. Lasts exactly GAP_CYCLES cycles, then IDLE.
- sent_valid/sent_id are registered: high for exactly the one cycle after the retiring SHIFT cycle. sent_id equals active_id.
- enable low while busy does not stall: the in-flight word completes, ser_enable is still driven, and only new grants are blocked.
- err_clear clears timeout_err next cycle. If set and clear occur in the same cycle, set wins.
- active_id holds its last value in IDLE.
- Latency with the team serializer, DATA_WIDTH=8, GAP_CYCLES=1, grant at cycle t:
  - LOAD t+1; SHIFT t+2..t+10 (ser_tx_done first high t+10).
  - GAP t+11 with sent_valid=1; IDLE t+12, where the next grant is possible.
  - Steady-state word period is 12 cycles.

Test Plan:
1. Single word: req 0 with 0xA5, serializer MSB_FIRST=1 attached -> serial_out 1,0,1,0,0,1,0,1 on cycles t+2..t+9; sent_valid=1, sent_id=0 at t+11; busy low at t+12.
2. Full load: all 4 req_valid held high, distinct data -> grants 0,1,2,3,0 exactly 12 cycles apart; each sent_id matches, with no data mix-up.
3. Fairness and wrap: only req 1 and 3 valid -> grant order 1,3,1,3. After 3, the pointer wraps to 0 and req 0 rising mid-run is granted next.
4. Watchdog: TIMEOUT=16, ser_tx_done forced 0 -> timeout_err rises 16 cycles after first SHIFT cycle, no sent_valid, IDLE after gap. err_clear clears it; set and clear together leaves 1.
5. Reset mid-SHIFT: rst at 4th SHIFT cycle -> next cycle all outputs 0, state IDLE, pointer 0. A still-valid req 2 (with req 0 idle) is granted freshly, and the serializer reloads its word.
6. enable dropped during SHIFT -> word completes with sent_valid; no new grant while enable=0 despite pending valid; grant occurs the first IDLE cycle after enable returns.
